uart_rx_core: RTL and testbench

Serial-frame receiver that consumes the two-flop-synchronized, idle-high serial line and turns 8N1 frames into bytes. Sits directly downstream of the input synchronizer. Detects start bits, samples each bit at mid-period and checks the stop bit. Holds the received byte in a one-deep output buffer with a ready/read handshake and error flags for the host-side logic.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/rx_bit_timer.sv | 52 +++++
 rtl/uart_rx_core.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and default frame geometry for the UART receive path.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: emits a one-cycle sample pulse at mid-bit and counts sampled data bits.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  input  logic half_sel,
  input  logic count_bit,
  output logic sample,
  output logic last_bit
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);

  // Terminal counts are one less than the period because the pulse itself
  // happens on the edge that would otherwise advance the timer.
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BITS_LAST = CW'(DATA_BITS - 1);

  logic [TW-1:0] timer_reg;
  logic [CW-1:0] bit_cnt_reg;

  assign sample   = enable && (timer_reg == (half_sel ? HALF_LAST : FULL_LAST));
  assign last_bit = sample && count_bit && (bit_cnt_reg == BITS_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (clear) begin
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (enable) begin
      if (sample) begin
        timer_reg <= '0;
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end
      if (sample && count_bit) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: start detect, mid-bit sampling, stop check and a
// one-deep output buffer with ready/read handshake and error flags.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

  rx_state_t state_reg, state_next;

  logic                 prev_in_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 data_ready_reg;
  logic                 overrun_reg;
  logic                 framing_reg;

  logic start_edge;
  logic sample;
  logic last_bit;
  logic timer_clear;
  logic timer_en;
  logic half_sel;
  logic count_bit;
  logic shift_en;
  logic load;
  logic set_ferr;

  assign start_edge = (state_reg == IDLE) && prev_in_reg && !serial_in;

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_bit_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (timer_clear),
    .enable    (timer_en),
    .half_sel  (half_sel),
    .count_bit (count_bit),
    .sample    (sample),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      prev_in_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      prev_in_reg <= serial_in;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    half_sel    = 1'b0;
    count_bit   = 1'b0;
    shift_en    = 1'b0;
    load        = 1'b0;
    set_ferr    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next  = START;
          timer_clear = 1'b1;
        end
      end
      START: begin
        timer_en = 1'b1;
        half_sel = 1'b1;
        // A line that is back high at mid-start was a glitch, not a frame.
        if (sample) begin
          state_next = serial_in ? IDLE : DATA;
        end
      end
      DATA: begin
        timer_en  = 1'b1;
        count_bit = 1'b1;
        if (sample) begin
          shift_en = 1'b1;
          if (last_bit) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        timer_en = 1'b1;
        if (sample) begin
          if (serial_in) begin
            state_next = LOAD;
          end else begin
            set_ferr   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      LOAD: begin
        load       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Data arrives LSB first, so each new bit enters at the MSB and shifts down.
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      if (gi == DATA_BITS - 1) begin : g_msb
        assign shift_next[gi] = serial_in;
      end else begin : g_low
        assign shift_next[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_next;
    end
  end

  // A load in the same cycle as a host read wins: the byte stays ready and
  // the read counts as having consumed the previous one, so no overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_reg    <= '0;
      data_ready_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      framing_reg    <= 1'b0;
    end else begin
      if (load) begin
        rx_data_reg    <= shift_reg;
        data_ready_reg <= 1'b1;
        if (data_read) begin
          overrun_reg <= 1'b0;
        end else if (data_ready_reg) begin
          overrun_reg <= 1'b1;
        end
      end else if (data_read) begin
        data_ready_reg <= 1'b0;
        overrun_reg    <= 1'b0;
      end

      if (start_edge) begin
        framing_reg <= 1'b0;
      end else if (set_ferr) begin
        framing_reg <= 1'b1;
      end
    end
  end

  assign rx_data       = rx_data_reg;
  assign data_ready    = data_ready_reg;
  assign overrun_error = overrun_reg;
  assign framing_error = framing_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level model updated at the edges where the
// receiver's outputs must change, compared against the DUT every cycle.
module tb_uart_rx_core;

  localparam int CPB   = 10;
  localparam int NBITS = 8;
  localparam int FLEN  = CPB * (NBITS + 2);

  logic             clk;
  logic             n_rst;
  logic             serial_in;
  logic             data_read;
  logic [NBITS-1:0] rx_data;
  logic             data_ready;
  logic             overrun_error;
  logic             framing_error;

  uart_rx_core dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output state.
  logic [NBITS-1:0] m_data;
  logic             m_ready;
  logic             m_ovr;
  logic             m_ferr;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_frame = 0;
  bit  chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_data", 32'(rx_data), 32'(m_data));
      check("data_ready", 32'(data_ready), 32'(m_ready));
      check("overrun_error", 32'(overrun_error), 32'(m_ovr));
      check("framing_error", 32'(framing_error), 32'(m_ferr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  task automatic host_read();
    m_ready = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Iteration k drives the line for edge t0+k; effects of that edge are applied after it.
  task automatic send_frame(input logic [NBITS-1:0] b, input logic stop_bit,
                            input int read_k, input int abort_k);
    logic [NBITS+1:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < FLEN; k++) begin
      if (k == abort_k) begin
        n_rst = 1'b0;
        model_reset();
        #1;
        check("abort_rx_data", 32'(rx_data), 32'h0);
        check("abort_ready", 32'(data_ready), 32'h0);
        check("abort_flags", 32'({overrun_error, framing_error}), 32'h0);
        serial_in = 1'b1;
        data_read = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        $display("frame %0d: byte=%02h aborted by reset at t0+%0d", n_frame, b, k);
        n_frame++;
        return;
      end
      serial_in = bits[k / CPB];
      data_read = (k == read_k);
      tick();
      if (k == 0) m_ferr = 1'b0;
      if (k == CPB / 2 + (NBITS + 1) * CPB && !stop_bit) m_ferr = 1'b1;
      if (k == CPB / 2 + (NBITS + 1) * CPB + 1 && stop_bit) begin
        m_data = b;
        if (k == read_k) m_ovr = 1'b0;
        else if (m_ready) m_ovr = 1'b1;
        m_ready = 1'b1;
      end else if (k == read_k) begin
        host_read();
      end
    end
    data_read = 1'b0;
    serial_in = 1'b1;
    $display("frame %0d: byte=%02h stop=%0b read_k=%0d -> rx_data=%02h ready=%0b ovr=%0b ferr=%0b",
             n_frame, b, stop_bit, read_k, rx_data, data_ready, overrun_error, framing_error);
    n_frame++;
  endtask

  task automatic idle(input int n, input int rd_at);
    for (int i = 0; i < n; i++) begin
      serial_in = 1'b1;
      data_read = (i == rd_at);
      tick();
      if (i == rd_at) host_read();
    end
    data_read = 1'b0;
  endtask

  // Line low for three cycles; the start sample at t0+5 must reject it and the
  // receiver must be ready for a new start edge at t0+6.
  task automatic false_start();
    for (int k = 0; k < CPB / 2 + 1; k++) begin
      serial_in = (k < 3) ? 1'b0 : 1'b1;
      data_read = 1'b0;
      tick();
      if (k == 0) m_ferr = 1'b0;
    end
    $display("false start: ready=%0b ferr=%0b", data_ready, framing_error);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [NBITS-1:0] b;
    logic             stop;
    int               rsel;
    int               rk;
    int               gap;

    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    model_reset();
    tick();
    tick();
    check("reset_rx_data", 32'(rx_data), 32'h0);
    check("reset_ready", 32'(data_ready), 32'h0);
    check("reset_overrun", 32'(overrun_error), 32'h0);
    check("reset_framing", 32'(framing_error), 32'h0);
    chk_en = 1'b1;
    n_rst  = 1'b1;
    idle(5, -1);

    send_frame(8'hA5, 1'b1, -1, -1);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_ready", 32'(data_ready), 32'h1);
    check("a5_errors", 32'({overrun_error, framing_error}), 32'h0);
    idle(4, 1);
    check("a5_read_ready", 32'(data_ready), 32'h0);

    false_start();
    send_frame(8'h3C, 1'b0, -1, -1);
    check("3c_framing", 32'(framing_error), 32'h1);
    check("3c_ready", 32'(data_ready), 32'h0);
    check("3c_data_kept", 32'(rx_data), 32'hA5);
    idle(3, -1);
    send_frame(8'h81, 1'b1, -1, -1);
    check("81_data", 32'(rx_data), 32'h81);
    check("81_framing", 32'(framing_error), 32'h0);
    idle(3, 0);

    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    check("22_data", 32'(rx_data), 32'h22);
    check("22_overrun", 32'(overrun_error), 32'h1);
    idle(3, 0);
    check("22_read_clear", 32'({data_ready, overrun_error}), 32'h0);

    send_frame(8'h33, 1'b1, -1, -1);
    send_frame(8'h5A, 1'b1, CPB / 2 + (NBITS + 1) * CPB + 1, -1);
    check("5a_data", 32'(rx_data), 32'h5A);
    check("5a_ready", 32'(data_ready), 32'h1);
    check("5a_overrun", 32'(overrun_error), 32'h0);

    send_frame(8'hC3, 1'b1, -1, CPB / 2 + 5 * CPB);
    idle(3, -1);
    send_frame(8'hF0, 1'b1, -1, -1);
    check("f0_data", 32'(rx_data), 32'hF0);
    check("f0_ready", 32'(data_ready), 32'h1);

    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 7) == 0) false_start();
      b    = NBITS'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      rsel = $urandom_range(0, 3);
      if (rsel == 0) rk = -1;
      else if (rsel == 1) rk = CPB / 2 + (NBITS + 1) * CPB + 1;
      else rk = $urandom_range(0, FLEN - 1);
      send_frame(b, stop, rk, -1);
      gap = stop ? $urandom_range(0, 12) : $urandom_range(1, 12);
      if (gap > 0) idle(gap, ($urandom_range(0, 1) == 1) ? $urandom_range(0, gap - 1) : -1);
    end

    idle(2, -1);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
